// File: rtl/sp_ram_stream_pkg.sv
// Shared types for the line-RAM stream reader: FSM states, widths and the
// word format held in the output FIFO.
package sp_ram_stream_pkg;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 18;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN
  } state_t;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } stream_word_t;

endpackage

// File: rtl/stream_fifo.sv
// Small synchronous FIFO of stream words. The producer is credit-limited,
// so a push is never presented while the FIFO is full without a pop.
module stream_fifo
  import sp_ram_stream_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         i_push,
  input  stream_word_t                 i_push_word,
  input  logic                         i_pop,
  output stream_word_t                 o_head,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_full,
  output logic                         o_empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  stream_word_t  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_pop;

  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_do_pop = i_pop && (r_count != '0);
  assign o_head   = r_mem[r_rd_ptr];
  assign o_count  = r_count;
  assign o_full   = (r_count == CW'(DEPTH));
  assign o_empty  = (r_count == '0);

  // Storage: data needs no reset, occupancy tracking decides what is valid.
  always_ff @(posedge clock) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_word;
  end

  // Pointers and occupancy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push)   r_wr_ptr <= f_next(r_wr_ptr);
      if (w_do_pop) r_rd_ptr <= f_next(r_rd_ptr);
      case ({i_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sp_ram_stream_reader.sv
// Reads LENGTH consecutive words from the single-port line RAM starting at
// BASE_ADDR (wrapping at 512) and streams them out with valid/ready. Reads
// are only issued when the words already in the RAM pipeline plus those in
// the output FIFO leave room, so backpressure can never drop data.
module sp_ram_stream_reader
  import sp_ram_stream_pkg::*;
#(
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic              ram_rden,
  output logic [ADDR_W-1:0] ram_address,
  input  logic [DATA_W-1:0] ram_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH + RD_LAT + 1);
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W-1:0] r_addr_hold;
  logic [ADDR_W:0]   r_rem_cnt;
  logic              r_done;
  logic [RD_LAT-1:0] r_inf_vld;
  logic [RD_LAT-1:0] r_inf_last;

  logic              w_accept;
  logic              w_credit;
  logic              w_issue;
  logic              w_issue_last;
  logic              w_pop;
  logic              w_pop_last;
  stream_word_t      w_push_word;
  stream_word_t      w_head;
  logic [FCNT_W-1:0] w_fifo_count;
  logic              w_fifo_full;
  logic              w_fifo_empty;

  function automatic logic [CNT_W-1:0] f_inflight(input logic [RD_LAT-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < RD_LAT; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

  // Start is refused in the done cycle so a finishing transfer cannot chain.
  assign w_accept     = (r_state == ST_IDLE) && start && (length != '0) && !r_done;
  assign w_credit     = !w_fifo_full &&
                        ((f_inflight(r_inf_vld) + CNT_W'(w_fifo_count)) < CNT_W'(FIFO_DEPTH));
  assign w_issue      = (r_state == ST_READ) && w_credit;
  assign w_issue_last = w_issue && (r_rem_cnt == (ADDR_W+1)'(1));
  assign w_pop        = !w_fifo_empty && out_ready;
  assign w_pop_last   = w_pop && w_head.last;

  assign w_push_word.last = r_inf_last[RD_LAT-1];
  assign w_push_word.data = ram_q;

  assign busy        = (r_state != ST_IDLE);
  assign done        = r_done;
  assign ram_rden    = w_issue;
  assign ram_address = w_issue ? r_rd_ptr : r_addr_hold;
  assign out_valid   = !w_fifo_empty;
  assign out_data    = w_fifo_empty ? '0 : w_head.data;
  assign out_last    = !w_fifo_empty && w_head.last;

  stream_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .i_push      (r_inf_vld[RD_LAT-1]),
    .i_push_word (w_push_word),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_fifo_count),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty)
  );

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next-state: fetch until the last read is issued, then drain the FIFO.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept)     w_state_nxt = ST_READ;
      ST_READ:  if (w_issue_last) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_pop_last)   w_state_nxt = ST_IDLE;
      default:                    w_state_nxt = ST_IDLE;
    endcase
  end

  // Read pointer, remaining count, held address, done pulse and the
  // in-flight tag pipeline that marks which RAM output cycles to capture.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_ptr    <= '0;
      r_rem_cnt   <= '0;
      r_addr_hold <= '0;
      r_done      <= 1'b0;
      r_inf_vld   <= '0;
      r_inf_last  <= '0;
    end else begin
      if (w_accept) begin
        r_rd_ptr  <= base_addr;
        r_rem_cnt <= length;
      end else if (w_issue) begin
        r_rd_ptr    <= r_rd_ptr + 1'b1;
        r_rem_cnt   <= r_rem_cnt - 1'b1;
        r_addr_hold <= r_rd_ptr;
      end
      r_done        <= (r_state == ST_DRAIN) && w_pop_last;
      r_inf_vld[0]  <= w_issue;
      r_inf_last[0] <= w_issue_last;
      for (int i = 1; i < RD_LAT; i++) begin
        r_inf_vld[i]  <= r_inf_vld[i-1];
        r_inf_last[i] <= r_inf_last[i-1];
      end
    end
  end

endmodule

// File: tb/tb_sp_ram_stream_reader.sv
module tb_sp_ram_stream_reader;

  logic        clock;
  logic        reset;
  logic        start;
  logic [8:0]  base_addr;
  logic [9:0]  length;
  logic        busy;
  logic        done;
  logic        ram_rden;
  logic [8:0]  ram_address;
  logic [17:0] ram_q;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] out_data;
  logic        out_last;

  int checks;
  int errors;

  // 512x18 single-port RAM, rden-gated first stage, free-running output register
  logic [17:0] mem [512];
  logic [17:0] ram_s1;

  always @(posedge clock) if (ram_rden) ram_s1 <= mem[ram_address];
  always @(posedge clock) ram_q <= ram_s1;

  sp_ram_stream_reader dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .base_addr   (base_addr),
    .length      (length),
    .busy        (busy),
    .done        (done),
    .ram_rden    (ram_rden),
    .ram_address (ram_address),
    .ram_q       (ram_q),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Results captured by run_xfer
  int          rden_cyc [$];
  int          addr_q   [$];
  logic [17:0] got_data [$];
  logic        got_last [$];
  int          got_cyc  [$];
  logic        busy_at  [0:1023];
  int          done_cyc;
  int          n_done;
  int          late_rden;
  int          max_out;
  int          unstable;

  function automatic logic [17:0] exp_word(input int a);
    return 18'(a % 512) ^ 18'h2A5A5;
  endfunction

  // Start one transfer (cycle 0) and record bus activity until done+3 or max_cyc.
  task automatic run_xfer(input logic [8:0] b, input logic [9:0] l, input int mode,
                          input int restart_cyc, input logic [8:0] rb, input logic [9:0] rl,
                          input int max_cyc);
    int outst;
    int post;
    logic prev_stall;
    logic [17:0] prev_data;
    rden_cyc.delete(); addr_q.delete(); got_data.delete(); got_last.delete(); got_cyc.delete();
    for (int i = 0; i < 1024; i++) busy_at[i] = 1'bx;
    done_cyc = -1; n_done = 0; late_rden = 0; max_out = 0; unstable = 0;
    outst = 0; post = 0; prev_stall = 1'b0; prev_data = '0;
    @(negedge clock);
    start = 1'b1; base_addr = b; length = l; out_ready = (mode == 0);
    #1;
    busy_at[0] = busy;
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      @(negedge clock);
      start = (cyc == restart_cyc);
      if (start) begin base_addr = rb; length = rl; end
      out_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      #1;
      busy_at[cyc] = busy;
      if (prev_stall && (!out_valid || out_data !== prev_data)) unstable++;
      if (ram_rden) begin
        rden_cyc.push_back(cyc);
        addr_q.push_back(int'(ram_address));
        if (done_cyc >= 0) late_rden++;
        if (outst + 1 > max_out) max_out = outst + 1;
        outst++;
      end
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_last.push_back(out_last);
        got_cyc.push_back(cyc);
        outst--;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (done_cyc >= 0) begin
        post++;
        if (post > 3) break;
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b1;
    idle_cycles(2);
    #1;
    checks++;
    if ({busy, done, ram_rden, ram_address, out_valid, out_data, out_last} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%h want=0",
               {busy, done, ram_rden, ram_address, out_valid, out_data, out_last});
    end
    @(negedge clock);
    reset = 1'b0;
    idle_cycles(2);
  endtask

  task automatic test_basic;
    int bad;
    run_xfer(9'd0, 10'd4, 0, -1, '0, '0, 60);
    checks++;
    if (busy_at[0] !== 1'b0) begin errors++; $display("FAIL basic_busy_c0 got=%b want=0", busy_at[0]); end
    checks++;
    if (rden_cyc.size() != 4) begin errors++; $display("FAIL basic_nrden got=%0d want=4", rden_cyc.size()); end
    bad = 0;
    for (int i = 0; i < 4; i++)
      if (i >= rden_cyc.size() || rden_cyc[i] != i + 1 || addr_q[i] != i) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL basic_rden_seq got=%0d_bad want=0_bad", bad); end
    bad = 0;
    for (int i = 0; i < 4; i++)
      if (i >= got_data.size() || got_cyc[i] != 4 + i || got_data[i] !== exp_word(i) ||
          got_last[i] !== (i == 3)) bad++;
    checks++;
    if (bad != 0 || got_data.size() != 4) begin
      errors++; $display("FAIL basic_words got=%0d_words_%0d_bad want=4_words_0_bad", got_data.size(), bad);
    end
    checks++;
    if (done_cyc != 8 || n_done != 1) begin
      errors++; $display("FAIL basic_done got=cyc%0d_n%0d want=cyc8_n1", done_cyc, n_done);
    end
    checks++;
    if (busy_at[7] !== 1'b1 || busy_at[8] !== 1'b0) begin
      errors++; $display("FAIL basic_busy_fall got=%b%b want=10", busy_at[7], busy_at[8]);
    end
    idle_cycles(2);
  endtask

  task automatic test_wrap;
    int bad;
    int exp_a [5] = '{510, 511, 0, 1, 2};
    run_xfer(9'd510, 10'd5, 0, -1, '0, '0, 60);
    bad = 0;
    for (int i = 0; i < 5; i++)
      if (i >= addr_q.size() || addr_q[i] != exp_a[i] || rden_cyc[i] != i + 1) bad++;
    checks++;
    if (bad != 0 || addr_q.size() != 5) begin
      errors++; $display("FAIL wrap_addr got=%0d_reads_%0d_bad want=5_reads_0_bad", addr_q.size(), bad);
    end
    bad = 0;
    for (int i = 0; i < 5; i++)
      if (i >= got_data.size() || got_data[i] !== exp_word(exp_a[i]) || got_last[i] !== (i == 4)) bad++;
    checks++;
    if (bad != 0 || got_data.size() != 5) begin
      errors++; $display("FAIL wrap_data got=%0d_words_%0d_bad want=5_words_0_bad", got_data.size(), bad);
    end
    checks++;
    if (done_cyc != 9) begin errors++; $display("FAIL wrap_done got=%0d want=9", done_cyc); end
    idle_cycles(2);
  endtask

  task automatic test_backpressure;
    int bad;
    int nlast;
    run_xfer(9'd16, 10'd32, 1, -1, '0, '0, 400);
    bad = 0; nlast = 0;
    for (int i = 0; i < got_data.size(); i++) begin
      if (got_data[i] !== exp_word(16 + i)) bad++;
      if (got_last[i]) nlast++;
    end
    checks++;
    if (got_data.size() != 32 || bad != 0) begin
      errors++; $display("FAIL bp_words got=%0d_words_%0d_bad want=32_words_0_bad", got_data.size(), bad);
    end
    checks++;
    if (nlast != 1 || got_data.size() == 0 || got_last[got_data.size()-1] !== 1'b1) begin
      errors++; $display("FAIL bp_last got=%0d_lasts want=1_on_final", nlast);
    end
    checks++;
    if (max_out > 4) begin errors++; $display("FAIL bp_credit got=%0d want<=4", max_out); end
    checks++;
    if (unstable != 0) begin errors++; $display("FAIL bp_stable got=%0d want=0", unstable); end
    checks++;
    if (n_done != 1) begin errors++; $display("FAIL bp_done got=%0d want=1", n_done); end
    idle_cycles(2);
  endtask

  task automatic test_full_ram;
    int bad;
    run_xfer(9'd0, 10'd512, 0, -1, '0, '0, 600);
    bad = 0;
    for (int i = 0; i < 512; i++)
      if (i >= rden_cyc.size() || rden_cyc[i] != i + 1 || addr_q[i] != i) bad++;
    checks++;
    if (bad != 0 || rden_cyc.size() != 512) begin
      errors++; $display("FAIL full_reads got=%0d_reads_%0d_bad want=512_reads_0_bad", rden_cyc.size(), bad);
    end
    bad = 0;
    for (int i = 0; i < 512; i++)
      if (i >= got_data.size() || got_data[i] !== exp_word(i) || got_cyc[i] != 4 + i) bad++;
    checks++;
    if (bad != 0 || got_data.size() != 512) begin
      errors++; $display("FAIL full_words got=%0d_words_%0d_bad want=512_words_0_bad", got_data.size(), bad);
    end
    checks++;
    if (done_cyc != 516) begin errors++; $display("FAIL full_done got=%0d want=516", done_cyc); end
    idle_cycles(2);
  endtask

  task automatic test_ignored_start;
    int bad;
    logic saw_busy, saw_rden, saw_done;
    // zero length
    @(negedge clock);
    start = 1'b1; base_addr = 9'd5; length = 10'd0;
    saw_busy = 1'b0; saw_rden = 1'b0; saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      start = 1'b0;
      #1;
      if (busy) saw_busy = 1'b1;
      if (ram_rden) saw_rden = 1'b1;
      if (done) saw_done = 1'b1;
    end
    checks++;
    if ({saw_busy, saw_rden, saw_done} !== 3'b000) begin
      errors++; $display("FAIL len0 got=%b want=000", {saw_busy, saw_rden, saw_done});
    end
    // start pulsed mid-transfer
    run_xfer(9'd40, 10'd6, 0, 3, 9'd200, 10'd2, 80);
    bad = 0;
    for (int i = 0; i < 6; i++)
      if (i >= addr_q.size() || addr_q[i] != 40 + i || i >= got_data.size() ||
          got_data[i] !== exp_word(40 + i)) bad++;
    checks++;
    if (bad != 0 || addr_q.size() != 6 || got_data.size() != 6 || n_done != 1) begin
      errors++;
      $display("FAIL busy_start got=%0d_reads_%0d_words_%0d_bad_%0d_done want=6_6_0_1",
               addr_q.size(), got_data.size(), bad, n_done);
    end
    // start coinciding with done
    idle_cycles(2);
    run_xfer(9'd8, 10'd2, 0, 6, 9'd20, 10'd3, 40);
    checks++;
    if (done_cyc != 6 || late_rden != 0 || busy_at[7] !== 1'b0 || busy_at[8] !== 1'b0) begin
      errors++;
      $display("FAIL done_start got=done%0d_late%0d_busy%b%b want=done6_late0_busy00",
               done_cyc, late_rden, busy_at[7], busy_at[8]);
    end
    idle_cycles(2);
  endtask

  task automatic test_mid_reset;
    int bad;
    @(negedge clock);
    start = 1'b1; base_addr = 9'd300; length = 10'd20; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      start = 1'b0;
    end
    #1;
    checks++;
    if (!(ram_rden && out_valid)) begin
      errors++; $display("FAIL mreset_setup got=rden%b_valid%b want=rden1_valid1", ram_rden, out_valid);
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, ram_rden, ram_address, out_valid, out_data, out_last} !== '0) begin
      errors++;
      $display("FAIL mreset_outputs got=%h want=0",
               {busy, done, ram_rden, ram_address, out_valid, out_data, out_last});
    end
    @(negedge clock);
    reset = 1'b0;
    out_ready = 1'b1;
    idle_cycles(3);
    run_xfer(9'd100, 10'd3, 0, -1, '0, '0, 40);
    bad = 0;
    for (int i = 0; i < 3; i++)
      if (i >= got_data.size() || got_data[i] !== exp_word(100 + i) || got_last[i] !== (i == 2) ||
          addr_q[i] != 100 + i) bad++;
    checks++;
    if (bad != 0 || got_data.size() != 3) begin
      errors++; $display("FAIL mreset_words got=%0d_words_%0d_bad want=3_words_0_bad", got_data.size(), bad);
    end
    checks++;
    if (done_cyc != 7 || n_done != 1) begin
      errors++; $display("FAIL mreset_done got=cyc%0d_n%0d want=cyc7_n1", done_cyc, n_done);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 512; i++) mem[i] = 18'(i) ^ 18'h2A5A5;
    ram_s1 = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_full_ram();
    test_ignored_start();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
